// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory request/response, downstream valid/ready
// instruction stream, and the redirect path from execute.
interface fetch_if #(
    parameter int PC_W    = 16,
    parameter int IMEM_AW = 6,
    parameter int INST_W  = 32
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INST_W-1:0]  imem_rdata;
    logic               inst_valid;
    logic               inst_ready;
    logic [INST_W-1:0]  inst_data;
    logic [PC_W-1:0]    inst_pc;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;

    // master is the fetch unit; slave is memory, execute and the downstream consumer
    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one-cycle-latency memory
// reads, a small prefetch queue, and redirect flush/squash.
module fetch_unit #(
    parameter int          PC_W     = 16,
    parameter int          IMEM_AW  = 6,
    parameter int          INST_W   = 32,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lock,
    fetch_if.master                bus,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   fetchPc_q, fetchPc_d;
    logic [PC_W-1:0]   pendPc_q;
    logic              pend_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rdPtr_q, wrPtr_q;
    logic [INST_W-1:0] instMem_q [DEPTH];
    logic [PC_W-1:0]   pcMem_q   [DEPTH];

    logic              imemReq;
    logic              push;
    logic              pop;
    logic              instValid;
    logic [CNT_W:0]    inFlight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lock)  state_d = RUN;
            RUN:     if (!lock) state_d = STALL;
            STALL:   if (lock)  state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Counting the in-flight read guarantees a slot for its response, so the queue never overflows.
    assign inFlight  = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
    assign imemReq   = (state_q == RUN) && lock && !bus.redirect_valid
                       && (inFlight < (CNT_W+1)'(DEPTH));
    assign instValid = (count_q != '0);
    assign pop       = instValid && bus.inst_ready;
    assign push      = pend_q && !bus.redirect_valid;

    always_comb begin
        fetchPc_d = fetchPc_q;
        if (bus.redirect_valid)
            fetchPc_d = bus.redirect_pc & ~PC_W'(3);
        else if (imemReq)
            fetchPc_d = fetchPc_q + PC_W'(4);
    end

    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (bus.redirect_valid)
            count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc_q <= PC_W'(RESET_PC);
            pendPc_q  <= '0;
            pend_q    <= 1'b0;
            count_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            pend_q    <= imemReq;
            if (imemReq)
                pendPc_q <= fetchPc_q;
            count_q <= count_d;
            if (bus.redirect_valid) begin
                rdPtr_q <= '0;
                wrPtr_q <= '0;
            end else begin
                if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
                if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            instMem_q[wrPtr_q] <= bus.imem_rdata;
            pcMem_q[wrPtr_q]   <= pendPc_q;
        end
    end

    assign bus.imem_req   = imemReq;
    assign bus.imem_addr  = rst_n ? fetchPc_q[IMEM_AW+1:2] : '0;
    assign bus.inst_valid = instValid;
    assign bus.inst_data  = instValid ? instMem_q[rdPtr_q] : '0;
    assign bus.inst_pc    = instValid ? pcMem_q[rdPtr_q] : '0;
    assign fifo_count     = count_q;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the execute datapath.
- Generates sequential PCs and issues reads to a synchronous instruction memory with one-cycle read latency.
- Buffers returned words with their PCs in a small prefetch queue and presents them downstream through a valid/ready handshake.
- Accepts branch/jump redirects from execute; a redirect flushes the queue and squashes any in-flight read.

Parameters:
- PC_W, 16, PC width in bits (byte address).
- IMEM_AW, 6, instruction memory word-address width; imem_addr = pc[IMEM_AW+1:2].
- INST_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries (power of 2, ≥2).
- RESET_PC, 0, PC fetched first after reset.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- lock, in, 1, run enable; low stops new fetch requests.
- imem_req, out, 1, read request; memory samples it at the rising edge.
- imem_addr, out, IMEM_AW, word address of the request.
- imem_rdata, in, INST_W, read data; valid in the cycle after the edge that sampled imem_req.
- inst_valid, out, 1, queue head is valid.
- inst_ready, in, 1, downstream accepts the head this cycle.
- inst_data, out, INST_W, head instruction.
- inst_pc, out, PC_W, PC of the head instruction.
- redirect_valid, in, 1, control-flow change from execute.
- redirect_pc, in, PC_W, new fetch PC; bits [1:0] are ignored (treated as 0).
- fifo_count, out, $clog2(DEPTH)+1, queue occupancy (debug).

Behaviour:
- Reset while rst_n=0, asynchronous:
  - fetch_pc=RESET_PC; queue empty; pend=0; state=IDLE.
  - Outputs: inst_valid=0, inst_data=0, inst_pc=0, fifo_count=0. imem_req=0, imem_addr=0.
  - Reset mid-operation discards all queued and in-flight data.
- FSM, registered:
  - IDLE → RUN when lock=1.
  - RUN → STALL when lock=0.
  - STALL → RUN when lock=1.
  - No transition out of IDLE until lock=1 is first seen.
- Request issue, combinational:
  - imem_req = (state==RUN) & lock & ~redirect_valid & (count + pend < DEPTH).
  - imem_addr = fetch_pc[IMEM_AW+1:2]. It is driven to fetch_pc even when imem_req=0, except in reset.
- Fetch PC update:
  - On an edge with imem_req=1: fetch_pc += 4, modulo 2^PC_W (wraps FFFC→0000).
  - When redirect_valid=1: fetch_pc = {redirect_pc[PC_W-1:2],2'b00}; no request is issued that cycle.
- In-flight tracking:
  - pend (1 bit) and pend_pc are set on each edge where imem_req=1.
  - On the next edge the response is pushed as {imem_rdata, pend_pc} unless squashed.
  - pend clears if no new request is issued.
- Squash: a redirect_valid=1 during the response cycle drops that response; pend clears.
- Latency:
  - Request sampled at edge N; word written at edge N+1; inst_valid=1 in the cycle after edge N+1.
  - Minimum 2 cycles from first issue to inst_valid.
  - After a redirect at edge R, the first redirected instruction is visible after edge R+2.
- Queue:
  - FIFO of {inst, pc}; head drives inst_data/inst_pc; inst_valid = (count≠0).
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - The count+pend<DEPTH gate guarantees no push to a full queue; overflow never occurs.
  - Pop when empty is ignored.
  - Read/write pointers wrap modulo DEPTH.
- Redirect priority:
  - redirect_valid=1 at an edge clears count, pointers and pend, and loads fetch_pc, regardless of simultaneous push or pop.
  - A head consumed in the same cycle (inst_valid&inst_ready) counts as delivered.
  - inst_valid=0 in the cycle after a redirect.
- lock=0:
  - No new requests.
  - An already-sampled request still returns and is pushed.
  - The downstream handshake continues; the queue drains normally.
  - fetch_pc holds.
- Back-pressure: with inst_ready=0, the queue fills to DEPTH and requests stop; fetch_pc holds at the next unfetched PC.

Test Plan:
- Reset release, lock=1, inst_ready=1, memory word k = k: inst_pc 0,4,8,C… with inst_data 0,1,2,3…; first inst_valid 2 cycles after first imem_req; steady state 1 instruction/cycle.
- inst_ready=0 for 10 cycles: fifo_count stops at 4, imem_req=0 once count+pend=4, no word lost. Then inst_ready=1: PCs resume 0x10, 0x14… contiguously.
- Redirect to 0x0042 in the response cycle of pc 0x08: that word is not delivered; queue cleared; next delivered inst_pc=0x0040, 2 cycles later; imem_addr=0x10.
- lock deasserted mid-stream: exactly one pending response still delivered, fetch_pc holds, no imem_req. Relock: fetch resumes at the held PC with no duplicate and no gap.
- RESET_PC=0xFFF8, wrap case: delivered PCs FFF8, FFFC, 0000, 0004.
- rst_n pulsed low asynchronously with the queue holding 3 entries: inst_valid=0 and fifo_count=0 immediately. After release, fetch restarts at RESET_PC.
